// File: rtl/ps2_hex_display.sv
`default_nettype none
// =============================================================================
// ps2_hex_display: PS/2 keyboard frame receiver driving a multi-digit hex
// seven-segment display (active-low), with optional break-code suppression.
// Revision: 1.0
// =============================================================================
module ps2_hex_display #(
    parameter int NUM_DIGITS     = 2,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int BREAK_FILTER   = 1
) (
    input  logic                      CLOCK,
    input  logic                      RESET,
    input  logic                      SCL,
    input  logic                      SDA,
    output logic [7:0]                RX_DATA,
    output logic                      DATA_VALID,
    output logic                      FRAME_ERR,
    output logic [7*NUM_DIGITS-1:0]   LED_SEG
);

    localparam int          TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam int          DW       = 4 * NUM_DIGITS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            scl_meta_q, scl_sync_q, scl_prev_q;
    logic            sda_meta_q, sda_sync_q;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [7:0]      rx_q, rx_d;
    logic            dv_q, dv_d;
    logic            err_q, err_d;
    logic            brk_q, brk_d;
    logic [DW-1:0]   disp_q, disp_d;
    logic [DW-1:0]   w_disp_shifted;
    logic            w_fe;
    logic            w_timeout;

    assign w_fe      = scl_prev_q & ~scl_sync_q;
    assign w_timeout = (state_q != IDLE) && (tmo_q == TMO_LAST);

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tmo_q      <= '0;
            rx_q       <= '0;
            dv_q       <= 1'b0;
            err_q      <= 1'b0;
            brk_q      <= 1'b0;
            disp_q     <= '0;
        end else begin
            scl_meta_q <= SCL;
            scl_sync_q <= scl_meta_q;
            scl_prev_q <= scl_sync_q;
            sda_meta_q <= SDA;
            sda_sync_q <= sda_meta_q;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
            rx_q       <= rx_d;
            dv_q       <= dv_d;
            err_q      <= err_d;
            brk_q      <= brk_d;
            disp_q     <= disp_d;
        end
    end

    // Frame FSM; an SCL falling edge takes priority over an expiring timeout.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        rx_d      = rx_q;
        dv_d      = 1'b0;
        err_d     = 1'b0;
        tmo_d     = (w_fe || state_q == IDLE) ? '0 : tmo_q + TW'(1);
        if (w_fe) begin
            case (state_q)
                IDLE: begin
                    if (!sda_sync_q) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d = {sda_sync_q, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d   = PARITY;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                PARITY: begin
                    par_d   = sda_sync_q;
                    state_d = STOP;
                end
                STOP: begin
                    if (sda_sync_q && (^{shift_q, par_q})) begin
                        rx_d = shift_q;
                        dv_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (w_timeout) begin
            state_d   = IDLE;
            err_d     = 1'b1;
            bit_cnt_d = '0;
        end
    end

    generate
        if (NUM_DIGITS == 2) begin : g_shift_min
            assign w_disp_shifted = rx_q;
        end else begin : g_shift_wide
            assign w_disp_shifted = {disp_q[DW-9:0], rx_q};
        end
    endgenerate

    // 0xF0 arms the break flag; the byte after it only disarms it.
    always_comb begin
        disp_d = disp_q;
        brk_d  = brk_q;
        if (dv_q) begin
            if ((BREAK_FILTER != 0) && brk_q) begin
                brk_d = 1'b0;
            end else if ((BREAK_FILTER != 0) && (rx_q == 8'hF0)) begin
                brk_d = 1'b1;
            end else begin
                disp_d = w_disp_shifted;
            end
        end
    end

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    generate
        for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
            assign LED_SEG[7*k +: 7] = hex7(disp_q[4*k +: 4]);
        end
    endgenerate

    assign RX_DATA    = rx_q;
    assign DATA_VALID = dv_q;
    assign FRAME_ERR  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_hex_display.sv
`default_nettype none
// =============================================================================
// tb_ps2_hex_display: scoreboard bench for two receiver configurations fed
// from one PS/2 stimulus stream. Revision: 1.0
// =============================================================================
module tb_ps2_hex_display;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b0;
    logic        SCL   = 1'b1;
    logic        SDA   = 1'b1;
    logic [7:0]  rx1, rx2;
    logic        dv1, dv2, fe1, fe2;
    logic [13:0] led1;
    logic [27:0] led2;

    ps2_hex_display #(.NUM_DIGITS(2), .TIMEOUT_CYCLES(100), .BREAK_FILTER(1)) dut1 (
        .CLOCK(CLOCK), .RESET(RESET), .SCL(SCL), .SDA(SDA),
        .RX_DATA(rx1), .DATA_VALID(dv1), .FRAME_ERR(fe1), .LED_SEG(led1)
    );

    ps2_hex_display #(.NUM_DIGITS(4), .TIMEOUT_CYCLES(100), .BREAK_FILTER(0)) dut2 (
        .CLOCK(CLOCK), .RESET(RESET), .SCL(SCL), .SDA(SDA),
        .RX_DATA(rx2), .DATA_VALID(dv2), .FRAME_ERR(fe2), .LED_SEG(led2)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        bit         err;
        logic [7:0] data;
    } exp_t;

    exp_t        q1[$];
    exp_t        q2[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          last_fe_cyc = 0;
    int          err_cyc1 = -1000;
    logic [7:0]  last1 = 8'h00;
    logic [7:0]  last2 = 8'h00;

    always @(posedge CLOCK) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge CLOCK) begin : mon1
        exp_t e;
        if (dv1 === 1'b1 || fe1 === 1'b1) begin
            if (q1.size() == 0) begin
                check("d1_unexpected", {30'd0, fe1, dv1}, 32'd0);
            end else begin
                e = q1.pop_front();
                check("d1_event", {30'd0, fe1, dv1}, e.err ? 32'd2 : 32'd1);
                check("d1_rx", {24'd0, rx1}, {24'd0, e.err ? last1 : e.data});
                if (!e.err) last1 = e.data;
                if (fe1) err_cyc1 = cyc;
            end
        end
    end

    always @(negedge CLOCK) begin : mon2
        exp_t e;
        if (dv2 === 1'b1 || fe2 === 1'b1) begin
            if (q2.size() == 0) begin
                check("d2_unexpected", {30'd0, fe2, dv2}, 32'd0);
            end else begin
                e = q2.pop_front();
                check("d2_event", {30'd0, fe2, dv2}, e.err ? 32'd2 : 32'd1);
                check("d2_rx", {24'd0, rx2}, {24'd0, e.err ? last2 : e.data});
                if (!e.err) last2 = e.data;
            end
        end
    end

    task automatic ps2_bit(input logic b);
        @(posedge CLOCK); #1;
        SDA = b;
        repeat (9) @(posedge CLOCK);
        #1;
        SCL = 1'b0;
        last_fe_cyc = cyc;
        repeat (10) @(posedge CLOCK);
        #1;
        SCL = 1'b1;
    endtask

    task automatic push_both(input bit err, input logic [7:0] d);
        exp_t e;
        e.err  = err;
        e.data = d;
        q1.push_back(e);
        q2.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_parity);
        push_both(bad_parity, b);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_parity);
        ps2_bit(1'b1);
        repeat (20) @(posedge CLOCK);
        #1;
    endtask

    // Start bit plus the first n-1 data bits, leaving SCL idle high.
    task automatic send_partial(input logic [7:0] b, input int n);
        ps2_bit(1'b0);
        for (int i = 0; i < n - 1; i++) ps2_bit(b[i]);
        SDA = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx1"}, {24'd0, rx1}, 32'h00);
        check({tag, "_rx2"}, {24'd0, rx2}, 32'h00);
        check({tag, "_flags"}, {28'd0, dv1, fe1, dv2, fe2}, 32'd0);
        check({tag, "_led1"}, {18'd0, led1}, {18'd0, {2{7'h40}}});
        check({tag, "_led2"}, {4'd0, led2}, {4'd0, {4{7'h40}}});
        check({tag, "_brk"}, {31'd0, dut1.brk_q}, 32'd0);
        check({tag, "_state"}, 32'(dut1.state_q), 32'd0);
        check({tag, "_cnt"}, {29'd0, dut1.bit_cnt_q}, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge CLOCK);
        #1;
        check_reset_values("rst");
        RESET = 1'b1;
        repeat (5) @(posedge CLOCK);
        #1;

        send_frame(8'h1C, 1'b0);
        check("1c_led1", {18'd0, led1}, {18'd0, 7'h79, 7'h46});
        check("1c_led2", {4'd0, led2}, {4'd0, 7'h40, 7'h40, 7'h79, 7'h46});

        send_frame(8'hF0, 1'b0);
        check("f0_led1", {18'd0, led1}, {18'd0, 7'h79, 7'h46});
        check("f0_brk", {31'd0, dut1.brk_q}, 32'd1);
        check("f0_led2", {4'd0, led2}, {4'd0, 7'h79, 7'h46, 7'h0E, 7'h40});

        send_frame(8'h1C, 1'b0);
        check("brk1c_led1", {18'd0, led1}, {18'd0, 7'h79, 7'h46});
        check("brk1c_brk", {31'd0, dut1.brk_q}, 32'd0);
        check("brk1c_led2", {4'd0, led2}, {4'd0, 7'h0E, 7'h40, 7'h79, 7'h46});

        send_frame(8'h1C, 1'b1);
        check("par_led1", {18'd0, led1}, {18'd0, 7'h79, 7'h46});
        check("par_led2", {4'd0, led2}, {4'd0, 7'h0E, 7'h40, 7'h79, 7'h46});

        push_both(1'b1, 8'h00);
        send_partial(8'h55, 5);
        repeat (150) @(posedge CLOCK);
        #1;
        check("to_latency", {31'd0, (err_cyc1 - last_fe_cyc >= 101) && (err_cyc1 - last_fe_cyc <= 105)}, 32'd1);
        check("to_state", 32'(dut1.state_q), 32'd0);
        check("to_cnt", {29'd0, dut1.bit_cnt_q}, 32'd0);

        send_frame(8'h12, 1'b0);
        check("12_led1", {18'd0, led1}, {18'd0, 7'h79, 7'h24});
        check("12_led2", {4'd0, led2}, {4'd0, 7'h79, 7'h46, 7'h79, 7'h24});

        send_frame(8'h34, 1'b0);
        check("34_led1", {18'd0, led1}, {18'd0, 7'h30, 7'h19});
        check("34_led2", {4'd0, led2}, {4'd0, 7'h79, 7'h24, 7'h30, 7'h19});

        send_partial(8'h77, 5);
        repeat (3) @(posedge CLOCK);
        #1;
        RESET = 1'b0;
        repeat (4) @(posedge CLOCK);
        #1;
        check_reset_values("midrst");
        last1 = 8'h00;
        last2 = 8'h00;
        RESET = 1'b1;
        repeat (5) @(posedge CLOCK);
        #1;

        send_frame(8'h1C, 1'b0);
        check("post_led1", {18'd0, led1}, {18'd0, 7'h79, 7'h46});
        check("post_led2", {4'd0, led2}, {4'd0, 7'h40, 7'h40, 7'h79, 7'h46});

        repeat (200) @(posedge CLOCK);
        #1;
        check("queues_drained", q1.size() + q2.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
